// File: rtl/button_char_debouncer.sv
// Button/DIP-switch front end for the ASCII LCD writer: synchronise, debounce, queue one
// character per press in a small FIFO. Optional macro BUTTON_AUTO_REPEAT_EN adds auto-repeat.
module button_char_debouncer #(
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int CNT_W           = 20,
   parameter int FIFO_AW         = 2
`ifdef BUTTON_AUTO_REPEAT_EN
   ,
   parameter int REPEAT_CYCLES   = 25000000
`endif
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             btn_raw,
   input  logic [7:0]       sw_raw,
   input  logic             debounce_en,
   output logic             char_valid,
   output logic [7:0]       char_data,
   input  logic             char_ready,
   output logic [FIFO_AW:0] fifo_count,
   output logic             overflow,
   output logic             btn_level
);

   localparam int                DEPTH    = 1 << FIFO_AW;
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [FIFO_AW:0]  FULL_CNT = (FIFO_AW + 1)'(DEPTH);

   typedef enum logic [1:0] {IDLE_LOW, WAIT_HIGH, HELD_HIGH, WAIT_LOW} state_t;

   logic               btn_sync_p0, btn_sync_p1;
   logic [7:0]         sw_sync_p0, sw_sync_p1;
   state_t             state, state_next;
   logic [CNT_W-1:0]   cnt, cnt_next;
   logic               level_next;
   logic               btn_level_d;
   logic               en_d;
   logic               edge_pulse;
   logic               press_pulse;
   logic               full, pop, push_ok;
   logic [7:0]         mem [DEPTH];
   logic [FIFO_AW-1:0] wr_ptr, rd_ptr;

   // Stage p0/p1: two-flop synchronisers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         btn_sync_p0 <= 1'b0;
         btn_sync_p1 <= 1'b0;
         sw_sync_p0  <= 8'h00;
         sw_sync_p1  <= 8'h00;
      end else begin
         btn_sync_p0 <= btn_raw;
         btn_sync_p1 <= btn_sync_p0;
         sw_sync_p0  <= sw_raw;
         sw_sync_p1  <= sw_sync_p0;
      end
   end

   // Debounce state register and debounced level
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= IDLE_LOW;
         cnt         <= '0;
         btn_level   <= 1'b0;
         btn_level_d <= 1'b0;
         en_d        <= 1'b0;
      end else begin
         state       <= state_next;
         cnt         <= cnt_next;
         btn_level   <= level_next;
         btn_level_d <= btn_level;
         en_d        <= debounce_en;
      end
   end

   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      level_next = btn_level;
      if (debounce_en != en_d) begin
         // Mode change: settle on the stable state of the current level, never emit an edge
         state_next = btn_level ? HELD_HIGH : IDLE_LOW;
         cnt_next   = '0;
      end else if (!debounce_en) begin
         level_next = btn_sync_p1;
         state_next = btn_sync_p1 ? HELD_HIGH : IDLE_LOW;
         cnt_next   = '0;
      end else begin
         case (state)
            IDLE_LOW: begin
               if (btn_sync_p1) begin
                  state_next = WAIT_HIGH;
                  cnt_next   = '0;
               end
            end
            WAIT_HIGH: begin
               if (!btn_sync_p1) begin
                  state_next = IDLE_LOW;
                  cnt_next   = '0;
               end else if (cnt == CNT_LAST) begin
                  state_next = HELD_HIGH;
                  level_next = 1'b1;
                  cnt_next   = '0;
               end else begin
                  cnt_next = cnt + CNT_W'(1);
               end
            end
            HELD_HIGH: begin
               if (!btn_sync_p1) begin
                  state_next = WAIT_LOW;
                  cnt_next   = '0;
               end
            end
            WAIT_LOW: begin
               if (btn_sync_p1) begin
                  state_next = HELD_HIGH;
                  cnt_next   = '0;
               end else if (cnt == CNT_LAST) begin
                  state_next = IDLE_LOW;
                  level_next = 1'b0;
                  cnt_next   = '0;
               end else begin
                  cnt_next = cnt + CNT_W'(1);
               end
            end
            default: begin
               state_next = IDLE_LOW;
               cnt_next   = '0;
            end
         endcase
      end
   end

   assign edge_pulse = btn_level & ~btn_level_d;

`ifdef BUTTON_AUTO_REPEAT_EN
   localparam int RPT_W = $clog2(REPEAT_CYCLES + 1);

   logic [RPT_W-1:0] rpt_cnt;
   logic             held;
   logic             rpt_pulse;

   assign held      = debounce_en ? (state == HELD_HIGH) : btn_level;
   assign rpt_pulse = held && (rpt_cnt == RPT_W'(REPEAT_CYCLES - 1));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         rpt_cnt <= '0;
      else if (!held || rpt_pulse)
         rpt_cnt <= '0;
      else
         rpt_cnt <= rpt_cnt + RPT_W'(1);
   end

   assign press_pulse = edge_pulse | rpt_pulse;
`else
   assign press_pulse = edge_pulse;
`endif

   // FIFO: a full FIFO still accepts a push when the head is popped in the same cycle
   assign full       = (fifo_count == FULL_CNT);
   assign pop        = char_valid & char_ready;
   assign push_ok    = press_pulse & (~full | pop);
   assign char_valid = (fifo_count != '0);
   assign char_data  = mem[rd_ptr];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= 8'h00;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
         overflow   <= 1'b0;
      end else begin
         if (push_ok) begin
            mem[wr_ptr] <= sw_sync_p1;
            wr_ptr      <= wr_ptr + FIFO_AW'(1);
         end
         if (pop)
            rd_ptr <= rd_ptr + FIFO_AW'(1);
         if (press_pulse & full & ~pop)
            overflow <= 1'b1;
         case ({push_ok, pop})
            2'b10:   fifo_count <= fifo_count + (FIFO_AW + 1)'(1);
            2'b01:   fifo_count <= fifo_count - (FIFO_AW + 1)'(1);
            default: fifo_count <= fifo_count;
         endcase
      end
   end

endmodule

// File: tb/tb_button_char_debouncer.sv
// Bench for button_char_debouncer: vector table, directed multi-cycle sequences and a
// randomized bypass-mode run against a delay-line + queue reference model.
module tb_button_char_debouncer;
   localparam int DB = 8;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       btn_raw;
   logic [7:0] sw_raw;
   logic       debounce_en;
   logic       char_valid;
   logic [7:0] char_data;
   logic       char_ready;
   logic [2:0] fifo_count;
   logic       overflow;
   logic       btn_level;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic       btn;
      logic [7:0] sw;
      logic       rdy;
      logic       v;
      logic [7:0] d;
      logic [2:0] c;
      logic       l;
   } vec_t;

   vec_t       tbl [8];
   bit         raw_h [$];
   logic [7:0] sw_h [$];
   logic [7:0] mq [$];
   bit         m_ovf;

   button_char_debouncer #(
      .DEBOUNCE_CYCLES(DB),
      .CNT_W(4),
      .FIFO_AW(2)
   ) dut (
      .clk(clk),
      .reset_n(reset_n),
      .btn_raw(btn_raw),
      .sw_raw(sw_raw),
      .debounce_en(debounce_en),
      .char_valid(char_valid),
      .char_data(char_data),
      .char_ready(char_ready),
      .fifo_count(fifo_count),
      .overflow(overflow),
      .btn_level(btn_level)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset_n     = 1'b0;
      btn_raw     = 1'b0;
      sw_raw      = 8'h00;
      char_ready  = 1'b0;
      debounce_en = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset_n = 1'b1;
   endtask

   task automatic press(input logic [7:0] s, input int hold, input int gap);
      btn_raw = 1'b1;
      sw_raw  = s;
      repeat (hold) tick();
      btn_raw = 1'b0;
      repeat (gap) tick();
   endtask

   task automatic drain(input string tag, input logic [7:0] first, input int n);
      for (int i = 0; i < n; i++) begin
         check($sformatf("%s_valid%0d", tag, i), char_valid, 1'b1);
         check($sformatf("%s_data%0d", tag, i), char_data, first + 8'(i));
         char_ready = 1'b1;
         tick();
         char_ready = 1'b0;
      end
      check($sformatf("%s_empty", tag), fifo_count, 3'd0);
   endtask

   initial begin
      tbl[0] = '{1'b1, 8'h83, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0};
      tbl[1] = '{1'b1, 8'h83, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0};
      tbl[2] = '{1'b1, 8'h83, 1'b0, 1'b0, 8'h00, 3'd0, 1'b1};
      tbl[3] = '{1'b1, 8'h83, 1'b0, 1'b1, 8'h83, 3'd1, 1'b1};
      tbl[4] = '{1'b1, 8'h83, 1'b1, 1'b0, 8'h00, 3'd0, 1'b1};
      tbl[5] = '{1'b0, 8'h83, 1'b0, 1'b0, 8'h00, 3'd0, 1'b1};
      tbl[6] = '{1'b0, 8'h83, 1'b0, 1'b0, 8'h00, 3'd0, 1'b1};
      tbl[7] = '{1'b0, 8'h83, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0};

      // Reset values
      reset_n     = 1'b0;
      btn_raw     = 1'b0;
      sw_raw      = 8'hFF;
      char_ready  = 1'b0;
      debounce_en = 1'b0;
      #1;
      check("rst_valid", char_valid, 1'b0);
      check("rst_data", char_data, 8'h00);
      check("rst_count", fifo_count, 3'd0);
      check("rst_ovf", overflow, 1'b0);
      check("rst_level", btn_level, 1'b0);
      do_reset();
      repeat (3) tick();

      // Bypass latency and single pop
      for (int i = 0; i < 8; i++) begin
         btn_raw    = tbl[i].btn;
         sw_raw     = tbl[i].sw;
         char_ready = tbl[i].rdy;
         tick();
         check($sformatf("byp%0d_valid", i), char_valid, tbl[i].v);
         if (tbl[i].v) check($sformatf("byp%0d_data", i), char_data, tbl[i].d);
         check($sformatf("byp%0d_count", i), fifo_count, tbl[i].c);
         check($sformatf("byp%0d_level", i), btn_level, tbl[i].l);
         check($sformatf("byp%0d_ovf", i), overflow, 1'b0);
      end
      char_ready = 1'b0;

      // Debounce: glitch rejected, clean press accepted at edge DB+4
      do_reset();
      debounce_en = 1'b1;
      repeat (4) tick();
      btn_raw = 1'b1;
      repeat (3) tick();
      btn_raw = 1'b0;
      for (int e = 0; e < 20; e++) begin
         tick();
         check("glitch_level", btn_level, 1'b0);
      end
      check("glitch_count", fifo_count, 3'd0);
      btn_raw = 1'b1;
      sw_raw  = 8'h41;
      for (int e = 1; e <= 20; e++) begin
         tick();
         check($sformatf("db_valid_e%0d", e), char_valid, (e >= DB + 4) ? 1'b1 : 1'b0);
         check($sformatf("db_level_e%0d", e), btn_level, (e >= DB + 3) ? 1'b1 : 1'b0);
      end
      check("db_data", char_data, 8'h41);
      check("db_count", fifo_count, 3'd1);
      btn_raw = 1'b0;
      repeat (20) tick();
      check("db_release_level", btn_level, 1'b0);
      check("db_release_count", fifo_count, 3'd1);
      drain("db_drain", 8'h41, 1);

      // Overflow on a fifth press with no consumer
      do_reset();
      repeat (2) tick();
      for (int i = 0; i < 5; i++) begin
         press(8'h30 + 8'(i), 4, 4);
         if (i == 3) begin
            check("ovf_pre_count", fifo_count, 3'd4);
            check("ovf_pre_flag", overflow, 1'b0);
         end
      end
      check("ovf_count", fifo_count, 3'd4);
      check("ovf_flag", overflow, 1'b1);
      drain("ovf_drain", 8'h30, 4);
      check("ovf_sticky", overflow, 1'b1);

      // Push and pop in the same cycle while full
      do_reset();
      repeat (2) tick();
      for (int i = 0; i < 4; i++) press(8'h50 + 8'(i), 4, 4);
      check("pp_full", fifo_count, 3'd4);
      btn_raw = 1'b1;
      sw_raw  = 8'h54;
      repeat (3) tick();
      char_ready = 1'b1;
      tick();
      char_ready = 1'b0;
      check("pp_count", fifo_count, 3'd4);
      check("pp_ovf", overflow, 1'b0);
      btn_raw = 1'b0;
      repeat (4) tick();
      drain("pp_drain", 8'h51, 4);
      check("pp_ovf_end", overflow, 1'b0);

      // Async reset during WAIT_HIGH with two characters queued
      do_reset();
      debounce_en = 1'b1;
      repeat (4) tick();
      press(8'h61, 14, 14);
      press(8'h62, 14, 14);
      check("ar_pre_count", fifo_count, 3'd2);
      btn_raw = 1'b1;
      sw_raw  = 8'h63;
      repeat (6) tick();
      reset_n = 1'b0;
      #1;
      check("ar_valid", char_valid, 1'b0);
      check("ar_data", char_data, 8'h00);
      check("ar_count", fifo_count, 3'd0);
      check("ar_ovf", overflow, 1'b0);
      check("ar_level", btn_level, 1'b0);
      @(posedge clk);
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      for (int e = 1; e <= 14; e++) begin
         tick();
         check($sformatf("ar_valid_e%0d", e), char_valid, (e >= DB + 4) ? 1'b1 : 1'b0);
      end
      check("ar_new_data", char_data, 8'h63);
      btn_raw = 1'b0;

      // Randomized bypass run against the reference model
      do_reset();
      raw_h.delete();
      sw_h.delete();
      mq.delete();
      m_ovf = 1'b0;
      repeat (4) begin
         raw_h.push_back(1'b0);
         sw_h.push_back(8'h00);
      end
      for (int cyc = 0; cyc < 600; cyc++) begin
         int  n;
         bit  m_pop;
         bit  m_push;
         bit  m_full;
         if ($urandom_range(3) == 0) btn_raw = ~btn_raw;
         sw_raw     = 8'($urandom);
         char_ready = (cyc < 300) ? ($urandom_range(2) == 0) : ($urandom_range(7) == 0);
         raw_h.push_back(btn_raw);
         sw_h.push_back(sw_raw);
         m_full = (mq.size() == 4);
         m_pop  = char_ready && (mq.size() != 0);
         tick();
         n      = raw_h.size() - 1;
         m_push = raw_h[n-3] && !raw_h[n-4];
         if (m_pop) void'(mq.pop_front());
         if (m_push) begin
            if (m_full && !m_pop) m_ovf = 1'b1;
            else mq.push_back(sw_h[n-2]);
         end
         check("rnd_valid", char_valid, (mq.size() != 0) ? 1'b1 : 1'b0);
         check("rnd_count", fifo_count, mq.size());
         check("rnd_level", btn_level, raw_h[n-2]);
         check("rnd_ovf", overflow, m_ovf);
         if (mq.size() != 0) check("rnd_data", char_data, mq[0]);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/button_char_debouncer.md
Name: button_char_debouncer

Overview:
- Front-end stage that feeds the ASCII LCD writer.
- Synchronises and debounces the raw push-button and the 8 DIP switches.
- On each debounced button press, captures the switch byte as an ASCII character and queues it in a small FIFO.
- Presents queued characters to the LCD writer over a valid/ready handshake, so presses made while the LCD is busy are not lost.

Parameters:
- DEBOUNCE_CYCLES, 1000000, number of consecutive stable clk cycles required to accept a level change (20 ms at 50 MHz).
- CNT_W, 20, width of the debounce counter; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.
- FIFO_AW, 2, FIFO address width; depth = 2^FIFO_AW = 4 entries.
- REPEAT_CYCLES, 25000000, auto-repeat period; used only with AUTO_REPEAT_EN.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- btn_raw  in  1  raw push-button, asynchronous, active-high.
- sw_raw  in  8  raw DIP switches (ASCII code), asynchronous.
- debounce_en  in  1  1 = debounce filter active; 0 = bypass, synchronised level used directly.
- char_valid  out  1  FIFO head holds a character.
- char_data  out  8  ASCII character at the FIFO head.
- char_ready  in  1  consumer accepts the head; a pop occurs when char_valid && char_ready.
- fifo_count  out  FIFO_AW+1  number of stored characters (0..4).
- overflow  out  1  sticky; a press was dropped because the FIFO was full.
- btn_level  out  1  debounced button level, for status LED.

Behaviour:
- Reset (asynchronous, reset_n=0): all synchroniser flops 0, FSM in IDLE_LOW, counter 0, FIFO pointers 0, char_valid=0, char_data=8'h00, fifo_count=0, overflow=0, btn_level=0.
- Synchronisers: 2-flop synchroniser on btn_raw and on each sw_raw bit. sw_sync is sampled at the press-edge cycle.
- Debounce FSM (debounce_en=1):
  - IDLE_LOW -> WAIT_HIGH when btn_sync=1; counter cleared.
  - WAIT_HIGH: counter increments while btn_sync=1. Return to IDLE_LOW if btn_sync=0 before the count reaches DEBOUNCE_CYCLES-1. On reaching DEBOUNCE_CYCLES-1 -> HELD_HIGH and btn_level<=1.
  - HELD_HIGH -> WAIT_LOW when btn_sync=0.
  - WAIT_LOW: symmetric to WAIT_HIGH; a full count -> IDLE_LOW with btn_level<=0; a glitch returns to HELD_HIGH.
- Bypass (debounce_en=0): btn_level<=btn_sync every cycle. FSM forced to IDLE_LOW or HELD_HIGH to match btn_sync; counter held at 0.
- debounce_en toggling mid-operation: FSM re-enters the stable state matching the current btn_level, counter cleared, no edge generated.
- Press pulse: one-cycle pulse when btn_level goes 0->1 (registered compare with btn_level_d). Release generates nothing.
- FIFO push: the press pulse writes sw_sync.
  - Full and no pop in the same cycle: write dropped, overflow<=1 (cleared only by reset).
  - Full with a simultaneous pop: push accepted, count unchanged.
- FIFO read: registered head. char_valid=(count!=0), char_data=mem[rd_ptr]. Pointers wrap modulo 2^FIFO_AW.
- Simultaneous push and pop when not full and not empty: count unchanged, both pointers advance.
- Push when empty: char_valid rises the cycle after the push edge.
- Latency, btn_raw rising to char_valid rising:
  - Bypass: exactly 4 clk edges (sync 2, level 1, FIFO write 1).
  - Debounce enabled: 4 + DEBOUNCE_CYCLES edges.
- char_data stays stable while char_valid=1 and char_ready=0.

Optional Feature:
- Macro BUTTON_AUTO_REPEAT_EN.
- Defined: while in HELD_HIGH (or while btn_level=1 in bypass), a repeat counter generates an additional press pulse every REPEAT_CYCLES cycles, capturing the current sw_sync. The counter is cleared on release and on reset. Overflow rules apply unchanged.
- Not defined: exactly one character per press; REPEAT_CYCLES and the repeat logic are absent.

Test Plan:
- Reset then bypass: debounce_en=0, btn_raw 0->1 with sw_raw=8'h83 -> char_valid=1 after 4 edges, char_data=8'h83, fifo_count=1; char_ready=1 for one cycle -> char_valid=0, fifo_count=0.
- Debounce filter, DEBOUNCE_CYCLES=8: 3-cycle glitch on btn_raw -> no push, btn_level stays 0. Clean press of 20 cycles with sw_raw=8'h41 -> single char 8'h41 at edge 12.
- Overflow: char_ready=0, five presses with 8'h30..8'h34 -> fifo_count=4, overflow=1. Draining yields 30,31,32,33 in order.
- Simultaneous push/pop while full: FIFO full with char_ready=1 in the press cycle -> count stays 4, overflow stays 0, new char appears last.
- Async reset mid-debounce: reset_n=0 during WAIT_HIGH with 2 chars queued -> all outputs 0 immediately. After release, the button must meet a full DEBOUNCE_CYCLES again.
- With BUTTON_AUTO_REPEAT_EN, REPEAT_CYCLES=16, bypass, hold 50 cycles, sw=8'h58 -> 1 + 3 characters, all 8'h58.
